// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared types and helpers for the router input datapath.
//   - state_t       : packet-capture FSM states
//   - MAX_CH        : largest supported channel count
//   - MAX_W         : widest word the header helpers accept
//   - get_dest()    : destination field (low ch_w bits of the header)
//   - get_len()     : payload-length field (header bits above the dest field)
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int MAX_CH = 16;
    localparam int MAX_W  = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    // Callers zero-extend the header to MAX_W and size-cast the result back.
    function automatic logic [MAX_W-1:0] get_dest(input logic [MAX_W-1:0] hdr,
                                                   input int unsigned     ch_w);
        return hdr & ((MAX_W'(1) << ch_w) - MAX_W'(1));
    endfunction

    function automatic logic [MAX_W-1:0] get_len(input logic [MAX_W-1:0] hdr,
                                                  input int unsigned     ch_w);
        return hdr >> ch_w;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// ---------------------------------------------------------------------------
// router_parity_acc
// Running XOR parity over a packet, with compare against the received parity.
// Ports:
//   clk, resetn   : clock, synchronous active-low reset
//   i_clr         : clear accumulator (new header accepted)
//   i_load        : load accumulator with i_load_val (header written)
//   i_load_val    : header word
//   i_acc         : XOR i_acc_val into accumulator (payload word accepted)
//   i_acc_val     : payload word
//   i_cmp_val     : received parity word
//   o_mismatch    : accumulator differs from i_cmp_val (combinational)
// ---------------------------------------------------------------------------
module router_parity_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic              i_acc,
    input  logic [DATA_W-1:0] i_acc_val,
    input  logic [DATA_W-1:0] i_cmp_val,
    output logic              o_mismatch
);

    logic [DATA_W-1:0] r_parity;

    // NOTE: sequential state is updated with <= so every register samples
    // pre-edge values, independent of statement or block ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_parity <= '0;
        end else if (i_clr) begin
            r_parity <= '0;
        end else if (i_load) begin
            r_parity <= i_load_val;
        end else if (i_acc) begin
            r_parity <= r_parity ^ i_acc_val;
        end
    end

    assign o_mismatch = (r_parity != i_cmp_val);

endmodule

// File: rtl/router_pkt_datapath.sv
// ---------------------------------------------------------------------------
// router_pkt_datapath
// Router input datapath: captures header/payload/parity packets, writes them
// to one of NUM_CH FIFOs over a shared bus, stalls on FIFO full and flags
// parity (and optionally length) errors.
// Optional feature macro: ROUTER_LEN_CHECK_EN (payload-count vs length field).
// Ports:
//   clk, resetn   : clock, synchronous active-low reset
//   pkt_valid     : source word valid (low on the parity word)
//   data_in       : source word
//   fifo_full     : per-channel FIFO full
//   soft_rst      : per-channel flush, aborts a packet to that channel
//   busy          : source must hold data_in/pkt_valid while high
//   dout          : FIFO write data
//   wr_en         : one-hot FIFO write strobe
//   parity_done   : pulse when the parity word is captured
//   err           : pulse the cycle after parity_done on parity mismatch
//   len_err       : pulse on payload-count mismatch (0 when feature disabled)
// ---------------------------------------------------------------------------
module router_pkt_datapath
    import router_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_CH = 3,
    localparam int CH_W   = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH),
    localparam int LEN_W  = DATA_W - CH_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0] fifo_full,
    input  logic [NUM_CH-1:0] soft_rst,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic [NUM_CH-1:0] wr_en,
    output logic              parity_done,
    output logic              err,
    output logic              len_err
);

    state_t            r_state;
    logic [CH_W-1:0]   r_dest;
    logic [DATA_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_pkt_par;
    logic [DATA_W-1:0] r_dout;
    logic [NUM_CH-1:0] r_wr_en;
    logic              r_busy;
    logic              r_parity_done;
    logic              r_err;

    logic [CH_W-1:0]   w_dest;
    logic              w_hdr_accept;
    logic              w_full;
    logic              w_abort;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_mismatch;

    assign w_dest       = CH_W'(get_dest(MAX_W'(data_in), CH_W));
    assign w_hdr_accept = (r_state == IDLE) && pkt_valid && (int'(w_dest) < NUM_CH);
    // r_dest is only meaningful outside IDLE, which is the only place these are used.
    assign w_full       = fifo_full[r_dest];
    assign w_abort      = soft_rst[r_dest];
    assign w_onehot     = NUM_CH'(1) << r_dest;

    router_parity_acc #(.DATA_W(DATA_W)) u_parity (
        .clk        (clk),
        .resetn     (resetn),
        .i_clr      (w_hdr_accept),
        .i_load     ((r_state == HDR) && !w_abort && !w_full),
        .i_load_val (r_hdr),
        .i_acc      ((r_state == LOAD) && !w_abort && pkt_valid),
        .i_acc_val  (data_in),
        .i_cmp_val  (r_pkt_par),
        .o_mismatch (w_mismatch)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_dest        <= '0;
            r_hdr         <= '0;
            r_hold        <= '0;
            r_pkt_par     <= '0;
            r_dout        <= '0;
            r_wr_en       <= '0;
            r_busy        <= 1'b0;
            r_parity_done <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // Strobes default low every cycle; branches below raise them.
            r_wr_en       <= '0;
            r_parity_done <= 1'b0;
            r_err         <= 1'b0;
            // busy is registered from the next state: high in HDR/HOLD/CHECK.
            case (r_state)
                IDLE: begin
                    if (w_hdr_accept) begin
                        r_dest  <= w_dest;
                        r_hdr   <= data_in;
                        r_state <= HDR;
                        r_busy  <= 1'b1;
                    end
                end
                HDR: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (!w_full) begin
                        r_dout  <= r_hdr;
                        r_wr_en <= w_onehot;
                        r_state <= LOAD;
                        r_busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else if (pkt_valid && !w_full) begin
                        r_dout  <= data_in;
                        r_wr_en <= w_onehot;
                    end else if (pkt_valid) begin
                        // Word is accepted now and replayed from r_hold later.
                        r_hold  <= data_in;
                        r_state <= HOLD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_pkt_par     <= data_in;
                        r_parity_done <= 1'b1;
                        r_state       <= CHECK;
                        r_busy        <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (!w_full) begin
                        r_dout  <= r_hold;
                        r_wr_en <= w_onehot;
                        r_state <= LOAD;
                        r_busy  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!w_abort) begin
                        r_err <= w_mismatch;
                    end
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROUTER_LEN_CHECK_EN
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic             r_len_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_len     <= '0;
            r_count   <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hdr_accept) begin
                        r_len   <= LEN_W'(get_len(MAX_W'(data_in), CH_W));
                        r_count <= '0;
                    end
                end
                LOAD: begin
                    // Saturates so an over-long packet cannot wrap to a match.
                    if (!w_abort && pkt_valid && (r_count != '1)) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                CHECK: begin
                    if (!w_abort) begin
                        r_len_err <= (r_count != r_len);
                    end
                end
                default: ;
            endcase
        end
    end

    assign len_err = r_len_err;
`else
    assign len_err = 1'b0;
`endif

    assign busy        = r_busy;
    assign dout        = r_dout;
    assign wr_en       = r_wr_en;
    assign parity_done = r_parity_done;
    assign err         = r_err;

endmodule

// File: doc/router_pkt_datapath.md
Name: router_pkt_datapath

Overview:
- Parametrised next-generation router input datapath with its own packet-capture FSM; no longer driven by external state strobes.
- Accepts byte/word packets (header, payload, parity) from the source and drives a single write bus plus one-hot write-enables to NUM_CH output FIFOs.
- Holds data while the destination FIFO is full, computes running XOR parity and flags parity and length errors.
- Sits between the router input port and the per-channel FIFOs; replaces the fixed 1x3, 8-bit register block.

Parameters:
- DATA_W, 8, word width; must be > CH_W.
- NUM_CH, 3, number of output channels, range 2..16.
- CH_W, max(1,$clog2(NUM_CH)), derived destination-field width; not for override.
- LEN_W, DATA_W-CH_W, derived payload-length field width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- pkt_valid  in  1  source word valid; high for header and payload, low on the parity word
- data_in  in  DATA_W  source word
- fifo_full  in  NUM_CH  per-channel FIFO full
- soft_rst  in  NUM_CH  per-channel flush; aborts any packet to that channel
- busy  out  1  source must hold data_in/pkt_valid stable while high
- dout  out  DATA_W  FIFO write data
- wr_en  out  NUM_CH  one-hot FIFO write strobe
- parity_done  out  1  one-cycle pulse when the parity word is captured
- err  out  1  one-cycle pulse, parity mismatch; issued the cycle after parity_done
- len_err  out  1  one-cycle pulse, payload count differs from length field (LEN_CHECK_EN only)

Behaviour:
- Reset: clk and resetn (synchronous, active-low) are already decided. On reset: FSM to IDLE; busy, wr_en, parity_done, err, len_err = 0; dout, header, hold register, parity accumulator and payload counter = 0.
- Header format: dest = data_in[CH_W-1:0]; len = data_in[DATA_W-1:CH_W]. Registered outputs only; wr_en asserted in the same cycle dout is updated.
- IDLE:
  - pkt_valid=1 and dest<NUM_CH: latch header, clear parity and count, go HDR.
  - dest>=NUM_CH: word ignored, stay IDLE, no write.
- HDR: busy=1.
  - If !fifo_full[dest]: dout<=header, wr_en[dest]=1, parity<=header, go LOAD.
  - Otherwise stay in HDR.
- LOAD:
  - pkt_valid=1, !fifo_full[dest]: dout<=data_in, wr_en[dest]=1, parity^=data_in, count+1.
  - pkt_valid=1, fifo_full[dest]: hold<=data_in, parity^=data_in, count+1, go HOLD. busy rises the next cycle; the word is accepted.
  - pkt_valid=0: pkt_par<=data_in, parity_done pulse, go CHECK. No FIFO write of the parity word.
- HOLD: busy=1.
  - When !fifo_full[dest]: dout<=hold, wr_en[dest]=1, go LOAD (busy drops the same edge).
- CHECK:
  - err<=(parity!=pkt_par).
  - len_err<=(count!=len) when LEN_CHECK_EN is defined.
  - Return to IDLE. Header acceptance is earliest the cycle after CHECK.
- Count: LEN_W bits, saturating at all-ones; no wrap.
- busy is high in HDR, HOLD and CHECK; low in IDLE and LOAD.
- soft_rst[dest] in any non-IDLE state: abort to IDLE next cycle with no write, no err and no parity_done. soft_rst of other channels is ignored. soft_rst in IDLE has no effect.
- fifo_full deasserting in the same cycle a word arrives: the current-cycle fifo_full value decides.
- resetn mid-packet: the packet is discarded entirely; resetn has priority over soft_rst.

Optional Feature:
- Macro: ROUTER_LEN_CHECK_EN.
- Defined: payload counter compare is performed; len_err pulses in CHECK on mismatch.
- Undefined: len_err is tied to 0; no compare logic, and the counter is not synthesised.

Decomposition:
- Package router_pkg holds:
  - FSM state enum (IDLE, HDR, LOAD, HOLD, CHECK).
  - Header field-extract functions get_dest / get_len, parameterised by DATA_W/CH_W.
  - Constant MAX_CH=16.
- One sub-module: router_parity_acc (clear, load, xor-accumulate, compare). The FSM and data registers stay in the top module.

Test Plan (DATA_W=8, NUM_CH=3):
- Clean packet: header 8'h0D (dest1, len3), payload 11,22,33, parity 8'h0D^11^22^33 = 8'h0D → wr_en=3'b010 for 4 cycles, dout = 0D,11,22,33; parity_done 1 pulse; err=0; len_err=0.
- Bad parity: same packet with parity 8'h00 → err=1 for one cycle, the cycle after parity_done.
- Full stall: fifo_full[1]=1 while the 2nd payload word is presented, held for 3 cycles → busy=1 for 3 cycles; word 22 written once, after fifo_full falls; no duplicate or lost word.
- Invalid destination: header 8'h07 (dest3) → no wr_en, FSM stays IDLE, busy=0.
- Length mismatch: header 8'h10 (dest0, len4), 3 payload words, correct parity (ROUTER_LEN_CHECK_EN defined) → len_err=1 pulse, err=0.
- Abort: soft_rst[2] asserted mid-packet to dest2 → next cycle IDLE, no further wr_en, no parity_done. A following packet to dest0 completes with err=0.
